daq_event_buffer: RTL and testbench

- Sits directly upstream of the memory interface block and is its only client.
- Accepts 32-bit DAQ words from the acquisition path through a valid/ready port and stages them in a small input FIFO.
- Drains the FIFO into external DDR as a 2^ADDR_W-word ring buffer using the memory block's write_req/read_req/busy handshake.
- Serves host readout of the oldest stored word and arbitrates between draining and readout.

---
 rtl/daq_pkg.sv | 14 +
 rtl/daq_event_buffer_sync_fifo.sv | 58 +++++
 rtl/daq_event_buffer.sv | 164 ++++++++++++++++
 tb/tb_daq_event_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared defaults and FSM encoding for the DAQ event buffer.
package daq_pkg;
  localparam int unsigned DAQ_DATA_W  = 32;
  localparam int unsigned DAQ_ADDR_W  = 20;
  localparam int unsigned DAQ_FIFO_AW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_e;
endpackage

// File: rtl/daq_event_buffer_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a first-word-fall-through head.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);
  assign head_o  = mem_q[rp_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/daq_event_buffer.sv
// Stages acquisition words in a FIFO, drains them into a DDR ring buffer and
// serves host readout of the oldest word, arbitrating between the two.
module daq_event_buffer
  import daq_pkg::*;
#(
  parameter int unsigned DATA_W  = DAQ_DATA_W,
  parameter int unsigned ADDR_W  = DAQ_ADDR_W,
  parameter int unsigned FIFO_AW = DAQ_FIFO_AW
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              host_rd_req,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_valid,
  output logic              host_rd_empty,
  input  logic              host_clear,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] mem_data_i,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_req,
  output logic              mem_read_req,
  input  logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_busy
);
  localparam logic [ADDR_W:0] RING_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, addr_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              wreq_q, rreq_q, rvalid_q, rempty_q, ovf_q;
  logic              rd_pend_q, clr_pend_q, last_wr_q, busy_seen_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              can_wr, can_rd, clr_now, wr_inflight, complete;

  assign in_ready      = !fifo_full;
  assign fifo_push     = in_valid && in_ready;
  assign fifo_pop      = (state_q == ST_WR_REQ) && !mem_busy;
  assign can_wr        = !fifo_empty && (count_q != RING_FULL);
  assign can_rd        = rd_pend_q && (count_q != '0);
  assign clr_now       = (state_q == ST_IDLE) && (host_clear || clr_pend_q);
  assign wr_inflight   = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
  assign complete      = busy_seen_q && !mem_busy;

  assign host_rd_data  = rdata_q;
  assign host_rd_valid = rvalid_q;
  assign host_rd_empty = rempty_q;
  assign overflow      = ovf_q;
  assign word_count    = count_q;
  assign mem_data_i    = wdata_q;
  assign mem_addr      = addr_q;
  assign mem_write_req = wreq_q;
  assign mem_read_req  = rreq_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (reset),
    .clr_i   (clr_now),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wreq_q      <= 1'b0;
      rreq_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rempty_q    <= 1'b0;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
      last_wr_q   <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rempty_q <= 1'b0;
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      if (host_clear && state_q != ST_IDLE) clr_pend_q <= 1'b1;

      // An empty ring only answers "empty" when no write could still land.
      if (host_rd_req && !rd_pend_q) begin
        if (count_q == '0 && !wr_inflight) rempty_q  <= 1'b1;
        else                               rd_pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          busy_seen_q <= 1'b0;
          if (clr_now) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            clr_pend_q <= 1'b0;
          end else if (can_wr && (!can_rd || !last_wr_q)) begin
            wreq_q    <= 1'b1;
            addr_q    <= wr_ptr_q;
            wdata_q   <= fifo_head;
            last_wr_q <= 1'b1;
            state_q   <= ST_WR_REQ;
          end else if (can_rd) begin
            rreq_q    <= 1'b1;
            addr_q    <= rd_ptr_q;
            last_wr_q <= 1'b0;
            state_q   <= ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!mem_busy) begin
            wreq_q  <= 1'b0;
            state_q <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (mem_busy) busy_seen_q <= 1'b1;
          if (complete) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            count_q  <= count_q + (ADDR_W+1)'(1);
            state_q  <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (!mem_busy) begin
            rreq_q  <= 1'b0;
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_busy) busy_seen_q <= 1'b1;
          if (complete) begin
            rdata_q   <= mem_data_o;
            rvalid_q  <= !(clr_pend_q || host_clear);
            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
            count_q   <= count_q - (ADDR_W+1)'(1);
            rd_pend_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_daq_event_buffer.sv
// Directed bench for daq_event_buffer on a 16-word ring with a behavioural memory block.
module tb_daq_event_buffer;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid, in_ready;
  logic          host_rd_req, host_rd_valid, host_rd_empty, host_clear, overflow;
  logic [31:0]   host_rd_data;
  logic [AW:0]   word_count;
  logic [31:0]   mem_data_i, mem_data_o;
  logic [AW-1:0] mem_addr;
  logic          mem_write_req, mem_read_req, mem_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  daq_event_buffer #(
    .DATA_W  (32),
    .ADDR_W  (AW),
    .FIFO_AW (4)
  ) dut (
    .sys_clk       (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .host_rd_req   (host_rd_req),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .host_rd_empty (host_rd_empty),
    .host_clear    (host_clear),
    .overflow      (overflow),
    .word_count    (word_count),
    .mem_data_i    (mem_data_i),
    .mem_addr      (mem_addr),
    .mem_write_req (mem_write_req),
    .mem_read_req  (mem_read_req),
    .mem_data_o    (mem_data_o),
    .mem_busy      (mem_busy)
  );

  // Memory block: accepts when idle, stays busy 3 cycles, logs every transaction.
  typedef struct { logic wr; logic [AW-1:0] addr; logic [31:0] data; } txn_t;
  txn_t        log_q[$];
  int unsigned busy_cnt = 0;
  logic [31:0] ram [16];
  logic [31:0] rdata_m;
  bit          both_high = 0;
  int          rd_req_cycles = 0;

  assign mem_busy   = (busy_cnt != 0);
  assign mem_data_o = rdata_m;

  always @(posedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (mem_write_req || mem_read_req) begin
      busy_cnt <= 3;
      log_q.push_back('{mem_write_req, mem_addr, mem_write_req ? mem_data_i : ram[mem_addr]});
      if (mem_write_req) ram[mem_addr] <= mem_data_i;
      else               rdata_m       <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_write_req && mem_read_req) both_high <= 1;
    if (mem_read_req) rd_req_cycles <= rd_req_cycles + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 400) begin tick(); n++; end
    if (n == 400) chk("push_ready_timeout", in_ready, 1);
    in_data = d; in_valid = 1; tick(); in_valid = 0;
  endtask

  task automatic host_read(output logic v, output logic e, output logic [31:0] d);
    int n = 0;
    host_rd_req = 1; tick(); host_rd_req = 0;
    while (!host_rd_valid && !host_rd_empty && n < 400) begin tick(); n++; end
    v = host_rd_valid; e = host_rd_empty; d = host_rd_data;
  endtask

  task automatic wait_cnt(input logic [AW:0] exp, input string name);
    int n = 0;
    while (word_count !== exp && n < 800) begin tick(); n++; end
    chk(name, word_count, exp);
  endtask

  task automatic read_expect(input logic [31:0] exp, input string name);
    logic v, e; logic [31:0] d;
    host_read(v, e, d);
    chk({name, "_valid"}, v, 1);
    chk({name, "_data"}, d, exp);
  endtask

  typedef enum int {OP_PUSH, OP_READ, OP_CNT, OP_LOGW, OP_LOGR} op_e;
  typedef struct { op_e op; logic [31:0] data; logic [AW:0] val; } vec_t;
  vec_t tbl[$];

  function automatic void add(input op_e op, input logic [31:0] data, input logic [AW:0] val);
    tbl.push_back('{op, data, val});
  endfunction

  initial begin
    int lp = 0;
    int n, f, start;
    logic [31:0] rd_got[$];

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp;
    int n, f, start, got;
    logic [31:0] rd_got[$];

    reset = 1; in_data = '0; in_valid = 0; host_rd_req = 0; host_clear = 0;
    repeat (3) tick();
    reset = 0;
    tick();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd_valid", host_rd_valid, 0);
    chk("rst_rd_empty", host_rd_empty, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_wreq", mem_write_req, 0);
    chk("rst_rreq", mem_read_req, 0);

    // Read on an empty ring: empty strobe one cycle later, no memory read.
    host_rd_req = 1; tick(); host_rd_req = 0;
    chk("empty_pulse", host_rd_empty, 1);
    chk("empty_no_valid", host_rd_valid, 0);
    tick();
    chk("empty_pulse_width", host_rd_empty, 0);
    repeat (8) tick();
    chk("empty_no_mem_read", rd_req_cycles, 0);

    for (int k = 1; k <= 5; k++) add(OP_PUSH, k, 0);
    add(OP_CNT, 0, 5);
    for (int k = 0; k < 5; k++) add(OP_LOGW, k + 1, k);
    add(OP_READ, 1, 0); add(OP_READ, 2, 0);
    add(OP_LOGR, 1, 0); add(OP_LOGR, 2, 1);
    add(OP_CNT, 0, 3);
    for (int k = 3; k <= 5; k++) add(OP_READ, k, 0);
    for (int k = 3; k <= 5; k++) add(OP_LOGR, k, k - 1);
    add(OP_CNT, 0, 0);
    for (int k = 0; k < 9; k++) begin
      add(OP_PUSH, 32'h100 + k, 0);
      add(OP_CNT, 0, 1);
      add(OP_READ, 32'h100 + k, 0);
      add(OP_LOGW, 32'h100 + k, 5 + k);
      add(OP_LOGR, 32'h100 + k, 5 + k);
    end
    for (int k = 0; k < 4; k++) add(OP_PUSH, 32'hA000_0000 + k, 0);
    add(OP_CNT, 0, 4);
    for (int k = 0; k < 4; k++) add(OP_LOGW, 32'hA000_0000 + k, (14 + k) % 16);
    for (int k = 0; k < 4; k++) add(OP_READ, 32'hA000_0000 + k, 0);
    for (int k = 0; k < 4; k++) add(OP_LOGR, 32'hA000_0000 + k, (14 + k) % 16);
    add(OP_CNT, 0, 0);

    lp = 0;
    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_PUSH: push(tbl[i].data);
        OP_READ: read_expect(tbl[i].data, $sformatf("v%0d_read", i));
        OP_CNT:  wait_cnt(tbl[i].val, $sformatf("v%0d_count", i));
        default: begin
          if (lp < log_q.size()) begin
            chk($sformatf("v%0d_log_type", i), log_q[lp].wr, tbl[i].op == OP_LOGW);
            chk($sformatf("v%0d_log_addr", i), log_q[lp].addr, tbl[i].val[AW-1:0]);
            chk($sformatf("v%0d_log_data", i), log_q[lp].data, tbl[i].data);
          end else begin
            chk($sformatf("v%0d_log_len", i), log_q.size(), lp + 1);
          end
          lp++;
        end
      endcase
    end
    chk("log_total", log_q.size(), lp);

    // Continuous input with a read always pending: W and R must alternate.
    start = log_q.size();
    fork
      begin
        for (int k = 0; k < 8; k++) push(32'hC000_0000 + k);
      end
      begin
        n = 0;
        while (word_count < 3 && n < 400) begin tick(); n++; end
        got = 0; n = 0;
        while (got < 8 && n < 1500) begin
          host_rd_req = 1; tick();
          if (host_rd_valid) begin rd_got.push_back(host_rd_data); got++; end
          n++;
        end
        host_rd_req = 0;
      end
    join
    chk("alt_read_count", rd_got.size(), 8);
    foreach (rd_got[i]) chk($sformatf("alt_data%0d", i), rd_got[i], 32'hC000_0000 + i);
    f = -1;
    for (int i = start; i < log_q.size(); i++) if (!log_q[i].wr) begin f = i; break; end
    if (f >= 0 && f + 6 <= log_q.size()) begin
      for (int j = 0; j < 6; j++) chk($sformatf("alt_order%0d", j), log_q[f + j].wr, (j % 2) == 1);
    end else begin
      chk("alt_window_len", log_q.size(), f + 6);
    end
    chk("never_both_req", both_high, 0);
    wait_cnt(0, "alt_drained");

    // Ring full plus full FIFO: in_ready drops, overflow latches, a read resumes draining.
    for (int k = 0; k < 32; k++) push(32'hF000_0000 + k);
    wait_cnt(16, "full_count");
    repeat (10) tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_no_ovf_yet", overflow, 0);
    in_data = 32'hDEAD_BEEF; in_valid = 1; tick(); in_valid = 0;
    chk("overflow_set", overflow, 1);
    read_expect(32'hF000_0000, "full_read");
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("ready_restored", in_ready, 1);
    wait_cnt(16, "refill_count");
    chk("refill_type", log_q[log_q.size() - 1].wr, 1);
    chk("refill_addr", log_q[log_q.size() - 1].addr, 10);
    chk("refill_data", log_q[log_q.size() - 1].data, 32'hF000_0010);
    chk("overflow_sticky", overflow, 1);

    // Clear during WR_WAIT: the write finishes, then everything resets.
    read_expect(32'hF000_0001, "pre_clear_read");
    n = 0;
    while (!mem_write_req && n < 100) begin tick(); n++; end
    n = 0;
    while (!mem_busy && n < 100) begin tick(); n++; end
    chk("clr_in_wr_wait", mem_busy, 1);
    host_clear = 1; tick(); host_clear = 0;
    wait_cnt(0, "clr_count");
    tick();
    chk("clr_overflow", overflow, 0);
    chk("clr_in_ready", in_ready, 1);
    push(32'h77);
    wait_cnt(1, "post_clr_count");
    chk("post_clr_addr", log_q[log_q.size() - 1].addr, 0);
    chk("post_clr_data", log_q[log_q.size() - 1].data, 32'h77);
    read_expect(32'h77, "post_clr_read");
    wait_cnt(0, "final_count");
    chk("never_both_req_end", both_high, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
